// File: rtl/fir_mac_scheduler_pkg.sv
// fir_sched_pkg: shared types and defaults for the FIR MAC scheduler.
//   sched_state_e : sequencer state (IDLE, WRITE, RUN)
//   *_DEF         : default channel count, tap count and MAC latency
//   idx_width()   : index width for a count, never narrower than one bit
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RUN   = 2'd2
  } sched_state_e;

  localparam int NUM_CH_DEF   = 20;
  localparam int NUM_TAPS_DEF = 32;
  localparam int MAC_LAT_DEF  = 2;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_mac_scheduler_valid_delay.sv
// sched_valid_delay: MAC_LAT-stage shift register carrying {valid, channel}
// so the result tag lines up with the shared MAC's output.
//   clk, rst   : clock, synchronous active-high clear of every stage
//   tap_last   : current cycle is a channel's final accumulate
//   tap_ch     : channel being accumulated
//   res_valid  : delayed tap_last (MAC output holds a finished result)
//   res_ch     : delayed channel tag
module sched_valid_delay #(
  parameter int MAC_LAT = 2,
  parameter int CH_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tap_last,
  input  logic [CH_W-1:0] tap_ch,
  output logic            res_valid,
  output logic [CH_W-1:0] res_ch
);

  logic            vld_p [MAC_LAT];
  logic [CH_W-1:0] ch_p  [MAC_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        vld_p[i] <= 1'b0;
        ch_p[i]  <= '0;
      end
    end else begin
      vld_p[0] <= tap_last;
      ch_p[0]  <= tap_ch;
      for (int i = 1; i < MAC_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        ch_p[i]  <= ch_p[i-1];
      end
    end
  end

  assign res_valid = vld_p[MAC_LAT-1];
  assign res_ch    = ch_p[MAC_LAT-1];

endmodule

// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: time-multiplexes one shared MAC across NUM_CH channels.
// Each accepted sample strobe runs a frame: per channel one WRITE cycle
// (new sample into history RAM) followed by NUM_TAPS RUN cycles.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : allows new frames to start
//   sample_stb   : new sample available for all channels
//   overrun_clr  : clears the sticky overrun flag
//   busy         : frame in progress
//   ch_idx       : channel being sequenced (RAM bank select)
//   wr_en/wr_ptr : history write strobe and circular write pointer
//   hist_ptr     : history read address (wr_ptr - tap_idx mod NUM_TAPS)
//   tap_idx      : coefficient ROM address
//   mac_clr/en   : MAC load-product / active controls
//   res_valid/ch : finished result and its channel tag
//   frame_done   : result of the last channel
//   overrun      : sticky, strobe arrived while busy
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int MAC_LAT  = MAC_LAT_DEF,
  localparam int CH_W    = idx_width(NUM_CH),
  localparam int TAP_W   = idx_width(NUM_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sample_stb,
  input  logic             overrun_clr,
  output logic             busy,
  output logic [CH_W-1:0]  ch_idx,
  output logic             wr_en,
  output logic [TAP_W-1:0] wr_ptr,
  output logic [TAP_W-1:0] hist_ptr,
  output logic [TAP_W-1:0] tap_idx,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             res_valid,
  output logic [CH_W-1:0]  res_ch,
  output logic             frame_done,
  output logic             overrun
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  sched_state_e state;
  logic         tap_last;

  // Modulo subtraction that also holds when NUM_TAPS is not a power of two.
  function automatic logic [TAP_W-1:0] hist_addr(input logic [TAP_W-1:0] w,
                                                 input logic [TAP_W-1:0] t);
    if (w >= t) return w - t;
    return TAP_W'(NUM_TAPS - int'(t) + int'(w));
  endfunction

  // Sequencer state and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch_idx  <= '0;
      tap_idx <= '0;
      wr_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      // A strobe during a frame is dropped; setting beats clearing.
      if (sample_stb && (state != IDLE)) overrun <= 1'b1;
      else if (overrun_clr)               overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (sample_stb && enable) begin
            state   <= WRITE;
            ch_idx  <= '0;
            tap_idx <= '0;
          end
        end
        WRITE: begin
          state   <= RUN;
          tap_idx <= '0;
        end
        RUN: begin
          if (tap_idx == LAST_TAP) begin
            tap_idx <= '0;
            if (ch_idx == LAST_CH) begin
              // All channels share one pointer, so it advances once per frame.
              ch_idx <= '0;
              wr_ptr <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
              state  <= IDLE;
            end else begin
              ch_idx <= ch_idx + 1'b1;
              state  <= WRITE;
            end
          end else begin
            tap_idx <= tap_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign wr_en    = (state == WRITE);
  assign mac_en   = (state == RUN);
  assign mac_clr  = (state == RUN) && (tap_idx == '0);
  assign hist_ptr = hist_addr(wr_ptr, tap_idx);
  assign tap_last = (state == RUN) && (tap_idx == LAST_TAP);

  // Result tag pipeline matching the MAC latency
  sched_valid_delay #(
    .MAC_LAT (MAC_LAT),
    .CH_W    (CH_W)
  ) u_valid_delay (
    .clk       (clk),
    .rst       (rst),
    .tap_last  (tap_last),
    .tap_ch    (ch_idx),
    .res_valid (res_valid),
    .res_ch    (res_ch)
  );

  assign frame_done = res_valid && (res_ch == LAST_CH);

endmodule
